ram_dump_reader: RTL and testbench

Sequential reader for the data RAM's read port: on START it walks a contiguous word range, presents each word on a valid/ready output stream, and reports a running checksum. It is the read-side counterpart to the core's data-memory write path (ADDR_W/ENABLE_W/Q_W). In simulation and on the bench it sits beside the single-cycle core and dumps result memory after a program has executed.

---
 rtl/ram_dump_pkg.sv | 21 ++
 rtl/ram_dump_reader.sv | 129 ++++++++++++
 tb/tb_ram_dump_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_dump_pkg
// Description : Shared definitions for the RAM dump reader. Holds the FSM
//               state type and the default RAM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_dump_pkg;

  // Default RAM geometry: 1K words of 32 bits.
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  // Reader states. IDLE waits for START; STREAM walks the word range.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

endpackage : ram_dump_pkg
`default_nettype wire

// File: rtl/ram_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_dump_reader
// Description : Sequential reader for the data RAM read port. On START it
//               walks BASE_ADDR .. BASE_ADDR+WORD_COUNT-1 (wrapping), streams
//               each word on a valid/ready interface and accumulates a
//               running modulo-2^data_width checksum of emitted words.
// Ports       : CLK, RESET_N      - clock, synchronous active-low reset
//               START, BASE_ADDR,
//               WORD_COUNT        - dump request, sampled only in IDLE
//               ADDR_RD, Q_RD     - RAM read port (Q_RD is asynchronous)
//               OUT_DATA, OUT_ADDR,
//               OUT_VALID, OUT_READY - output word stream
//               BUSY, DONE        - status (DONE is a one-cycle pulse)
//               CHECKSUM          - sum of all words emitted this dump
// Revision    : 1.0 - initial release
// ============================================================================
module ram_dump_reader
  import ram_dump_pkg::*;
#(
  parameter int addr_width = ADDR_W_DEF,
  parameter int data_width = DATA_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic [addr_width-1:0] BASE_ADDR,
  input  logic [addr_width:0]   WORD_COUNT,
  output logic [addr_width-1:0] ADDR_RD,
  input  logic [data_width-1:0] Q_RD,
  output logic [data_width-1:0] OUT_DATA,
  output logic [addr_width-1:0] OUT_ADDR,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [data_width-1:0] CHECKSUM
);

  state_t                  state_q,     state_d;
  logic [addr_width-1:0]   addr_q,      addr_d;
  logic [addr_width:0]     remaining_q, remaining_d;
  logic [data_width-1:0]   out_data_q,  out_data_d;
  logic [addr_width-1:0]   out_addr_q,  out_addr_d;
  logic                    out_valid_q, out_valid_d;
  logic                    done_q,      done_d;
  logic [data_width-1:0]   checksum_q,  checksum_d;

  // Output slot is free when empty or being drained this cycle.
  logic slot_free_w;
  assign slot_free_w = !out_valid_q || OUT_READY;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    checksum_d  = checksum_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          checksum_d = '0;
          if (WORD_COUNT != '0) begin
            addr_d      = BASE_ADDR;
            remaining_d = WORD_COUNT;
            state_d     = ST_STREAM;
          end else begin
            // Empty dump: complete immediately without touching the stream.
            done_d = 1'b1;
          end
        end
      end

      ST_STREAM: begin
        if (slot_free_w && (remaining_q != '0)) begin
          // Capture the word now addressed; RAM read data is combinational.
          out_data_d  = Q_RD;
          out_addr_d  = addr_q;
          out_valid_d = 1'b1;
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          checksum_d  = checksum_q + Q_RD;
        end else if (out_valid_q && OUT_READY && (remaining_q == '0)) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          done_d      = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  assign ADDR_RD   = addr_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_ADDR  = out_addr_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = (state_q == ST_STREAM);
  assign DONE      = done_q;
  assign CHECKSUM  = checksum_q;

endmodule : ram_dump_reader
`default_nettype wire

// File: tb/tb_ram_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_dump_reader
// Description : Directed self-checking bench for ram_dump_reader. The RAM is
//               modelled as an asynchronous array holding mem[a] = 3*a.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_dump_reader;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic [9:0]  BASE_ADDR;
  logic [10:0] WORD_COUNT;
  logic [9:0]  ADDR_RD;
  logic [31:0] Q_RD;
  logic [31:0] OUT_DATA;
  logic [9:0]  OUT_ADDR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        BUSY;
  logic        DONE;
  logic [31:0] CHECKSUM;

  logic [31:0] mem [1024];
  assign Q_RD = mem[ADDR_RD];

  ram_dump_reader #(.addr_width(10), .data_width(32)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .START     (START),
    .BASE_ADDR (BASE_ADDR),
    .WORD_COUNT(WORD_COUNT),
    .ADDR_RD   (ADDR_RD),
    .Q_RD      (Q_RD),
    .OUT_DATA  (OUT_DATA),
    .OUT_ADDR  (OUT_ADDR),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .CHECKSUM  (CHECKSUM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Captured stream words.
  logic [31:0] got_d [16];
  logic [9:0]  got_a [16];
  int          n_got;

  // Consume a dump already started. Bit i of rdy_pat drives OUT_READY on
  // cycle i; beyond pat_len OUT_READY stays high. Returns once DONE is seen.
  task automatic collect(input logic [15:0] rdy_pat, input int pat_len, input int max_cyc);
    logic        prev_hold;
    logic [31:0] prev_d;
    logic [9:0]  prev_a;
    logic        seen_done;
    n_got     = 0;
    prev_hold = 1'b0;
    prev_d    = '0;
    prev_a    = '0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < max_cyc && !seen_done; cyc++) begin
      OUT_READY = (cyc < pat_len) ? rdy_pat[cyc] : 1'b1;
      if (prev_hold) begin
        check_eq("hold_data", OUT_DATA, prev_d);
        check_eq("hold_addr", {22'd0, OUT_ADDR}, {22'd0, prev_a});
        check_eq("hold_valid", {31'd0, OUT_VALID}, 32'd1);
      end
      if (OUT_VALID && OUT_READY && n_got < 16) begin
        got_d[n_got] = OUT_DATA;
        got_a[n_got] = OUT_ADDR;
        n_got++;
      end
      prev_hold = OUT_VALID && !OUT_READY;
      prev_d    = OUT_DATA;
      prev_a    = OUT_ADDR;
      if (DONE) seen_done = 1'b1;
      else tick();
    end
    check_eq("done_seen", {31'd0, seen_done}, 32'd1);
    OUT_READY = 1'b1;
  endtask

  task automatic start_dump(input logic [9:0] base, input logic [10:0] cnt);
    BASE_ADDR  = base;
    WORD_COUNT = cnt;
    START      = 1'b1;
    tick();
    START      = 1'b0;
  endtask

  logic [31:0] exp_basic [4];

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 32'(3 * a);
    exp_basic[0] = 32'h30; exp_basic[1] = 32'h33;
    exp_basic[2] = 32'h36; exp_basic[3] = 32'h39;

    // ---------------- reset with START held high
    RESET_N = 1'b0; START = 1'b1; BASE_ADDR = 10'h055; WORD_COUNT = 11'd4; OUT_READY = 1'b1;
    tick(); tick();
    check_eq("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    check_eq("rst_busy",  {31'd0, BUSY}, 32'd0);
    check_eq("rst_done",  {31'd0, DONE}, 32'd0);
    check_eq("rst_csum",  CHECKSUM, 32'd0);
    check_eq("rst_addr_rd", {22'd0, ADDR_RD}, 32'd0);
    check_eq("rst_out_data", OUT_DATA, 32'd0);
    check_eq("rst_out_addr", {22'd0, OUT_ADDR}, 32'd0);
    START = 1'b0; RESET_N = 1'b1;
    tick();

    // ---------------- basic dump, ready always high, cycle-exact
    start_dump(10'h010, 11'd4);
    check_eq("basic_busy_k", {31'd0, BUSY}, 32'd1);
    check_eq("basic_valid_k", {31'd0, OUT_VALID}, 32'd0);
    check_eq("basic_addr_rd_k", {22'd0, ADDR_RD}, 32'h010);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("basic_valid", {31'd0, OUT_VALID}, 32'd1);
      check_eq("basic_data", OUT_DATA, exp_basic[i]);
      check_eq("basic_addr", {22'd0, OUT_ADDR}, 32'h010 + 32'(i));
      check_eq("basic_done_early", {31'd0, DONE}, 32'd0);
    end
    tick();
    check_eq("basic_done", {31'd0, DONE}, 32'd1);
    check_eq("basic_valid_end", {31'd0, OUT_VALID}, 32'd0);
    check_eq("basic_busy_end", {31'd0, BUSY}, 32'd0);
    check_eq("basic_csum", CHECKSUM, 32'hD2);
    tick();
    check_eq("basic_done_drop", {31'd0, DONE}, 32'd0);
    check_eq("basic_csum_hold", CHECKSUM, 32'hD2);

    // ---------------- zero-length dump
    start_dump(10'h010, 11'd0);
    check_eq("zero_done", {31'd0, DONE}, 32'd1);
    check_eq("zero_valid", {31'd0, OUT_VALID}, 32'd0);
    check_eq("zero_busy", {31'd0, BUSY}, 32'd0);
    check_eq("zero_csum", CHECKSUM, 32'd0);
    tick();
    check_eq("zero_done_drop", {31'd0, DONE}, 32'd0);
    check_eq("zero_valid2", {31'd0, OUT_VALID}, 32'd0);

    // ---------------- backpressure: ready 1,0,0,1,0,1,1 once words flow
    start_dump(10'h010, 11'd4);
    tick();  // first word now valid
    collect(16'b0000_0000_0110_1001, 7, 60);
    check_eq("bp_count", 32'(n_got), 32'd4);
    for (int i = 0; i < 4 && i < n_got; i++) begin
      check_eq("bp_data", got_d[i], exp_basic[i]);
      check_eq("bp_addr", {22'd0, got_a[i]}, 32'h010 + 32'(i));
    end
    check_eq("bp_csum", CHECKSUM, 32'hD2);
    tick();
    check_eq("bp_done_drop", {31'd0, DONE}, 32'd0);

    // ---------------- address wrap at top of RAM
    start_dump(10'h3FE, 11'd4);
    collect(16'hFFFF, 0, 40);
    check_eq("wrap_count", 32'(n_got), 32'd4);
    if (n_got == 4) begin
      check_eq("wrap_a0", {22'd0, got_a[0]}, 32'h3FE);
      check_eq("wrap_a1", {22'd0, got_a[1]}, 32'h3FF);
      check_eq("wrap_a2", {22'd0, got_a[2]}, 32'h000);
      check_eq("wrap_a3", {22'd0, got_a[3]}, 32'h001);
      check_eq("wrap_d0", got_d[0], 32'hBFA);
      check_eq("wrap_d2", got_d[2], 32'h0);
    end
    check_eq("wrap_csum", CHECKSUM, 32'h17FA);
    tick();

    // ---------------- START ignored mid-dump, then reset abort
    start_dump(10'h020, 11'd8);
    tick();
    check_eq("abort_w0", OUT_DATA, 32'h60);
    BASE_ADDR = 10'h100; WORD_COUNT = 11'd1; START = 1'b1;
    tick();
    START = 1'b0;
    check_eq("ign_addr", {22'd0, OUT_ADDR}, 32'h021);
    check_eq("ign_data", OUT_DATA, 32'h63);
    check_eq("ign_busy", {31'd0, BUSY}, 32'd1);
    tick();
    check_eq("abort_w2_addr", {22'd0, OUT_ADDR}, 32'h022);
    RESET_N = 1'b0;
    tick();
    check_eq("abort_valid", {31'd0, OUT_VALID}, 32'd0);
    check_eq("abort_done", {31'd0, DONE}, 32'd0);
    check_eq("abort_busy", {31'd0, BUSY}, 32'd0);
    check_eq("abort_csum", CHECKSUM, 32'd0);
    check_eq("abort_addr_rd", {22'd0, ADDR_RD}, 32'd0);
    RESET_N = 1'b1;
    tick();
    check_eq("abort_done_after", {31'd0, DONE}, 32'd0);
    check_eq("abort_valid_after", {31'd0, OUT_VALID}, 32'd0);

    // ---------------- normal 2-word dump after abort
    start_dump(10'h005, 11'd2);
    collect(16'hFFFF, 0, 20);
    check_eq("post_count", 32'(n_got), 32'd2);
    if (n_got == 2) begin
      check_eq("post_d0", got_d[0], 32'hF);
      check_eq("post_d1", got_d[1], 32'h12);
      check_eq("post_a1", {22'd0, got_a[1]}, 32'h006);
    end
    check_eq("post_csum", CHECKSUM, 32'h21);
    tick();
    check_eq("post_done_drop", {31'd0, DONE}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_ram_dump_reader
`default_nettype wire
